apb_nn_seq_ctrl: RTL and testbench

- APB-programmed sequencer for the neural-network accelerator datapath.
- Buffers input words written over APB, streams them to the accelerator with a valid strobe, waits for the finish pulse, and captures the result stream into readable registers.
- Provides status, a cycle counter, a timeout watchdog and a completion interrupt.
- Sits as one APB slave in the peripheral map, between the APB bus and the accelerator top.

---
 rtl/apb_nn_seq_pkg.sv | 29 ++
 rtl/nn_in_fifo.sv | 49 ++++
 rtl/apb_nn_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_apb_nn_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_nn_seq_pkg.sv
// Shared definitions for the APB neural-network sequencer: FSM encodings,
// register word indices and STATUS field positions.
package apb_nn_seq_pkg;

  typedef logic [2:0] nn_state_t;

  localparam nn_state_t ST_IDLE  = 3'd0;
  localparam nn_state_t ST_START = 3'd1;
  localparam nn_state_t ST_FEED  = 3'd2;
  localparam nn_state_t ST_WAIT  = 3'd3;
  localparam nn_state_t ST_DONE  = 3'd4;

  // Register word indices (byte offset >> 2)
  localparam logic [5:0] REG_CTRL    = 6'h00;
  localparam logic [5:0] REG_STATUS  = 6'h01;
  localparam logic [5:0] REG_LEN     = 6'h02;
  localparam logic [5:0] REG_DIN     = 6'h03;
  localparam logic [5:0] REG_CYCLES  = 6'h04;
  localparam logic [5:0] REG_TIMEOUT = 6'h05;
  localparam logic [5:0] REG_IRQ_EN  = 6'h06;
  localparam logic [5:0] REG_RESULT  = 6'h08;

  localparam int STAT_BUSY    = 3;
  localparam int STAT_DONE    = 4;
  localparam int STAT_TMO     = 5;
  localparam int STAT_OVF     = 6;
  localparam int STAT_LVL_LSB = 8;

endpackage

// File: rtl/nn_in_fifo.sv
// Synchronous input FIFO with first-word fall-through read port and flush.
module nn_in_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge HCLK) begin
    if (HRESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_nn_seq_ctrl.sv
// APB slave that feeds buffered input words to the NN accelerator, waits for
// completion and captures the result stream, with watchdog and interrupt.
module apb_nn_seq_ctrl
  import apb_nn_seq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int IN_DEPTH       = 16,
  parameter int OUT_NUM        = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      nn_start,
  output logic [31:0]               nn_data,
  output logic                      nn_data_valid,
  input  logic [31:0]               nn_res,
  input  logic                      nn_res_valid,
  input  logic                      nn_finish,
  output logic                      irq
);
  localparam int LVL_W = $clog2(IN_DEPTH) + 1;
  localparam int RC_W  = $clog2(OUT_NUM + 1);

  nn_state_t        state;
  logic [15:0]      len_r;
  logic [15:0]      fed_cnt;
  logic [RC_W-1:0]  res_cnt;
  logic [31:0]      cycles_r;
  logic [31:0]      timeout_r;
  logic             irq_en_r;
  logic             done_r;
  logic             tmo_err_r;
  logic             ovf_r;
  logic [31:0]      result_r [OUT_NUM];

  logic             apb_wr, apb_rd;
  logic [5:0]       reg_idx;
  logic             ctrl_wr, status_wr, din_wr;
  logic             start_req, abort_req, run_start;
  logic             busy, in_run, tmo_raw, tmo_hit, feed_go, res_take;
  logic [31:0]      fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [31:0]      status_c;
  logic             unused_addr;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign apb_wr      = PSEL && PENABLE && PWRITE;
  assign apb_rd      = PSEL && PENABLE && !PWRITE;
  assign reg_idx     = PADDR[7:2];
  assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:8], PADDR[1:0]};
  assign ctrl_wr     = apb_wr && (reg_idx == REG_CTRL);
  assign status_wr   = apb_wr && (reg_idx == REG_STATUS);
  assign din_wr      = apb_wr && (reg_idx == REG_DIN);

  // abort beats start when both are in one CTRL write
  assign start_req = ctrl_wr && PWDATA[0] && !PWDATA[1];
  assign abort_req = ctrl_wr && PWDATA[1];
  assign run_start = start_req && (state == ST_IDLE);

  assign busy    = (state == ST_START) || (state == ST_FEED) || (state == ST_WAIT);
  assign in_run  = (state == ST_FEED) || (state == ST_WAIT);
  assign tmo_raw = in_run && (timeout_r != 32'd0) && (cycles_r == timeout_r);
  assign tmo_hit = tmo_raw && !abort_req && !((state == ST_WAIT) && nn_finish);
  assign feed_go = (state == ST_FEED) && !fifo_empty && !tmo_raw;
  assign res_take = in_run && nn_res_valid && (res_cnt < RC_W'(OUT_NUM));

  nn_in_fifo #(.DEPTH(IN_DEPTH), .WIDTH(32)) u_fifo (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .push   (din_wr),
    .pop    (feed_go),
    .flush  (abort_req || tmo_hit),
    .wdata  (PWDATA),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign nn_start      = (state == ST_START);
  assign nn_data       = fifo_rdata;
  assign nn_data_valid = feed_go;
  assign irq           = done_r && irq_en_r;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else if (abort_req) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_req) state <= ST_START;
        ST_START: state <= (len_r != 16'd0) ? ST_FEED : ST_WAIT;
        ST_FEED: begin
          if (tmo_hit) state <= ST_IDLE;
          else if (feed_go && (fed_cnt + 16'd1 == len_r)) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (nn_finish)    state <= ST_DONE;
          else if (tmo_hit) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      len_r     <= '0;
      timeout_r <= '0;
      irq_en_r  <= 1'b0;
      done_r    <= 1'b0;
      tmo_err_r <= 1'b0;
      ovf_r     <= 1'b0;
      cycles_r  <= '0;
      fed_cnt   <= '0;
      res_cnt   <= '0;
      for (int i = 0; i < OUT_NUM; i++) result_r[i] <= '0;
    end else begin
      if (apb_wr && (reg_idx == REG_LEN))     len_r     <= PWDATA[15:0];
      if (apb_wr && (reg_idx == REG_TIMEOUT)) timeout_r <= PWDATA;
      if (apb_wr && (reg_idx == REG_IRQ_EN))  irq_en_r  <= PWDATA[0];

      // set conditions take priority over a simultaneous W1C
      if (run_start)                                done_r <= 1'b0;
      else if (state == ST_DONE)                    done_r <= 1'b1;
      else if (status_wr && PWDATA[STAT_DONE])      done_r <= 1'b0;

      if (tmo_hit)                                  tmo_err_r <= 1'b1;
      else if (status_wr && PWDATA[STAT_TMO])       tmo_err_r <= 1'b0;

      if (din_wr && fifo_full)                      ovf_r <= 1'b1;
      else if (status_wr && PWDATA[STAT_OVF])       ovf_r <= 1'b0;

      if (run_start)                                cycles_r <= '0;
      else if (busy && !abort_req && !tmo_raw)      cycles_r <= sat_inc32(cycles_r);

      if (run_start)    fed_cnt <= '0;
      else if (feed_go) fed_cnt <= fed_cnt + 16'd1;

      if (run_start) begin
        res_cnt <= '0;
        for (int i = 0; i < OUT_NUM; i++) result_r[i] <= '0;
      end else if (res_take) begin
        res_cnt <= res_cnt + 1'b1;
        for (int i = 0; i < OUT_NUM; i++)
          if (res_cnt == RC_W'(i)) result_r[i] <= nn_res;
      end
    end
  end

  always_comb begin
    status_c                          = '0;
    status_c[2:0]                     = state;
    status_c[STAT_BUSY]               = busy;
    status_c[STAT_DONE]               = done_r;
    status_c[STAT_TMO]                = tmo_err_r;
    status_c[STAT_OVF]                = ovf_r;
    status_c[STAT_LVL_LSB +: 8]       = 8'(fifo_level);
  end

  always_comb begin
    PRDATA = '0;
    if (apb_rd) begin
      case (reg_idx)
        REG_STATUS:  PRDATA = status_c;
        REG_LEN:     PRDATA = {16'd0, len_r};
        REG_CYCLES:  PRDATA = cycles_r;
        REG_TIMEOUT: PRDATA = timeout_r;
        REG_IRQ_EN:  PRDATA = {31'd0, irq_en_r};
        default:     PRDATA = '0;
      endcase
      for (int i = 0; i < OUT_NUM; i++)
        if (reg_idx == REG_RESULT + 6'(i)) PRDATA = result_r[i];
    end
  end

endmodule

// File: tb/tb_apb_nn_seq_ctrl.sv
// Directed bench for apb_nn_seq_ctrl: APB programming plus a hand-driven
// accelerator, with a monitor logging start pulses and issued input words.
module tb_apb_nn_seq_ctrl;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        nn_start;
  logic [31:0] nn_data;
  logic        nn_data_valid;
  logic [31:0] nn_res;
  logic        nn_res_valid;
  logic        nn_finish;
  logic        irq;

  int total = 0;
  int bad = 0;

  int          starts = 0;
  int          cyc = 0;
  logic [31:0] words[$];
  int          vcyc[$];

  apb_nn_seq_ctrl #(.APB_ADDR_WIDTH(12), .IN_DEPTH(16), .OUT_NUM(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .nn_start(nn_start), .nn_data(nn_data), .nn_data_valid(nn_data_valid),
    .nn_res(nn_res), .nn_res_valid(nn_res_valid), .nn_finish(nn_finish),
    .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    #1;
    if (nn_start) starts++;
    if (nn_data_valid) begin
      words.push_back(nn_data);
      vcyc.push_back(cyc);
    end
    cyc++;
  end

  localparam logic [11:0] A_CTRL = 12'h000, A_STAT = 12'h004, A_LEN = 12'h008,
                          A_DIN = 12'h00C, A_CYC = 12'h010, A_TMO = 12'h014,
                          A_IEN = 12'h018, A_RES = 12'h020;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // called just after a negedge; returns just after the following negedge pair
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge HCLK); PENABLE = 1'b1;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge HCLK); PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check_val(tag, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic finish_pulse();
    nn_finish = 1'b1; @(negedge HCLK); nn_finish = 1'b0;
  endtask

  initial begin
    int s0, w0;
    HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    nn_res = '0; nn_res_valid = 1'b0; nn_finish = 1'b0;
    idle(3);
    HRESET = 1'b0;
    @(negedge HCLK);

    // reset state
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    check_val("rst_start", {31'd0, nn_start}, 32'd0);
    check_val("rst_valid", {31'd0, nn_data_valid}, 32'd0);
    rd_chk("rst_status", A_STAT, 32'h0);
    rd_chk("rst_cycles", A_CYC, 32'h0);
    rd_chk("unmapped_rd", 12'h01C, 32'h0);

    // 1: basic run, 8 results, irq and W1C
    apb_write(A_LEN, 32'd4);
    apb_write(A_IEN, 32'd1);
    for (int i = 1; i <= 4; i++) apb_write(A_DIN, 32'h11 * i);
    rd_chk("t1_level", A_STAT, 32'h0000_0400);
    rd_chk("t1_len", A_LEN, 32'd4);
    rd_chk("ctrl_reads0", A_CTRL, 32'h0);
    s0 = starts; w0 = words.size();
    apb_write(A_CTRL, 32'h1);
    idle(6);
    for (int i = 0; i < 8; i++) begin
      nn_res = 32'h100 + i; nn_res_valid = 1'b1; @(negedge HCLK);
    end
    nn_res_valid = 1'b0;
    finish_pulse();
    idle(3);
    check_val("t1_starts", starts - s0, 1);
    check_val("t1_nwords", words.size() - w0, 4);
    for (int i = 0; i < 4 && w0 + i < words.size(); i++)
      check_val($sformatf("t1_word%0d", i), words[w0+i], 32'h11 * (i + 1));
    if (words.size() - w0 >= 4)
      check_val("t1_consecutive", vcyc[w0+3] - vcyc[w0], 3);
    check_val("t1_irq", {31'd0, irq}, 32'd1);
    rd_chk("t1_status", A_STAT, 32'h10);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("t1_res%0d", i), A_RES + 12'(4 * i), 32'h100 + i);
    apb_write(A_STAT, 32'h10);
    check_val("t1_irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("t1_status_clr", A_STAT, 32'h0);

    // 2: stalls while FIFO empty, WAIT only after third word
    apb_write(A_LEN, 32'd3);
    apb_write(A_DIN, 32'hA1);
    w0 = words.size();
    apb_write(A_CTRL, 32'h1);
    idle(3);
    apb_write(A_DIN, 32'hA2);
    rd_chk("t2_feed", A_STAT, 32'h0A);
    apb_write(A_DIN, 32'hA3);
    idle(1);
    rd_chk("t2_wait", A_STAT, 32'h0B);
    check_val("t2_nwords", words.size() - w0, 3);
    if (words.size() - w0 >= 3) begin
      check_val("t2_w2", words[w0+2], 32'hA3);
      check_val("t2_gap", {31'd0, (vcyc[w0+2] - vcyc[w0]) > 2}, 32'd1);
    end
    finish_pulse();
    idle(2);
    rd_chk("t2_done", A_STAT, 32'h10);
    apb_write(A_STAT, 32'h10);

    // 3: overflow on 17th write
    for (int i = 0; i < 17; i++) apb_write(A_DIN, 32'h300 + i);
    rd_chk("t3_ovf", A_STAT, 32'h0000_1040);
    apb_write(A_LEN, 32'd16);
    w0 = words.size();
    apb_write(A_CTRL, 32'h1);
    idle(24);
    check_val("t3_nwords", words.size() - w0, 16);
    if (words.size() - w0 >= 16)
      check_val("t3_last", words[w0+15], 32'h30F);
    rd_chk("t3_wait", A_STAT, 32'h4B);
    finish_pulse();
    idle(2);
    apb_write(A_STAT, 32'h70);
    rd_chk("t3_clr", A_STAT, 32'h0);

    // 4: watchdog timeout flushes FIFO, leaves done clear
    apb_write(A_TMO, 32'd20);
    apb_write(A_LEN, 32'd0);
    apb_write(A_DIN, 32'h55);
    apb_write(A_CTRL, 32'h1);
    idle(30);
    rd_chk("t4_status", A_STAT, 32'h20);
    rd_chk("t4_cycles", A_CYC, 32'd20);
    check_val("t4_irq", {31'd0, irq}, 32'd0);
    apb_write(A_STAT, 32'h20);
    apb_write(A_TMO, 32'd0);

    // 5: start while busy ignored, abort after 3 words
    apb_write(A_LEN, 32'd8);
    for (int i = 1; i <= 5; i++) apb_write(A_DIN, 32'h500 + i);
    s0 = starts; w0 = words.size();
    apb_write(A_CTRL, 32'h1);
    apb_write(A_CTRL, 32'h1);
    apb_write(A_CTRL, 32'h2);
    check_val("t5_valid_low", {31'd0, nn_data_valid}, 32'd0);
    idle(2);
    check_val("t5_starts", starts - s0, 1);
    check_val("t5_nwords", words.size() - w0, 3);
    rd_chk("t5_status", A_STAT, 32'h0);
    // abort+start in one write: abort wins; abort in IDLE still flushes
    apb_write(A_DIN, 32'h77);
    s0 = starts;
    apb_write(A_CTRL, 32'h3);
    idle(2);
    check_val("t5_ab_start", starts - s0, 0);
    rd_chk("t5_ab_status", A_STAT, 32'h0);

    // 6: LEN=0 with result coincident with finish
    apb_write(A_LEN, 32'd0);
    w0 = words.size();
    apb_write(A_CTRL, 32'h1);
    @(negedge HCLK);
    nn_res = 32'hABCD; nn_res_valid = 1'b1; nn_finish = 1'b1;
    @(negedge HCLK);
    nn_res_valid = 1'b0; nn_finish = 1'b0;
    idle(2);
    check_val("t6_nwords", words.size() - w0, 0);
    rd_chk("t6_res0", A_RES, 32'hABCD);
    rd_chk("t6_res1", A_RES + 12'h4, 32'h0);
    rd_chk("t6_status", A_STAT, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
